// File: rtl/verirq_pkg.sv
// Shared types and byte-lane merge helpers for the verirq interrupt controller.
package verirq_pkg;

    typedef enum logic [2:0] {
        PENDING_ADDRESS    = 3'd0,
        ENABLE_ADDRESS     = 3'd1,
        EDGE_MODE_ADDRESS  = 3'd2,
        CLAIM_ADDRESS      = 3'd3,
        IN_SERVICE_ADDRESS = 3'd4
    } local_address_t;

    typedef enum logic {
        IDLE,
        CLAIMED
    } state_t;

    typedef logic [4:0] source_id_t;

    // Replace only the bytes selected by wstrobe.
    function automatic logic [31:0] write_into(input logic [31:0] old_value,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrobe);
        logic [31:0] merged;
        merged = old_value;
        for (int b = 0; b < 4; b++) begin
            if (wstrobe[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        end
        return merged;
    endfunction

    // Clear bits written as 1 within the selected bytes.
    function automatic logic [31:0] clear_into(input logic [31:0] old_value,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  wstrobe);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            if (wstrobe[b]) mask[8*b +: 8] = wdata[8*b +: 8];
        end
        return old_value & ~mask;
    endfunction

endpackage

// File: rtl/verbus.sv
// Verbus register-access bundle; the responder drives rdata, ready and irq.
interface Verbus;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;

    modport read_write_response (
        input  valid, address, wstrobe, wdata,
        output rdata, ready, irq
    );
endinterface

// File: rtl/verirq_priority_encoder.sv
// Combinational priority pick: lowest set request index wins, reported as index+1.
module verirq_priority_encoder
    import verirq_pkg::*;
#(
    parameter int SOURCE_COUNT = 8
) (
    input  logic [SOURCE_COUNT-1:0] request_i,
    output logic                    valid_o,
    output source_id_t              id_o
);

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int i = SOURCE_COUNT - 1; i >= 0; i--) begin
            if (request_i[i]) begin
                valid_o = 1'b1;
                id_o    = source_id_t'(i + 1);
            end
        end
    end

endmodule

// File: rtl/verirq_controller.sv
// Interrupt controller: latches pending sources, masks them and runs claim/complete.
// irq follows registered state combinationally; bus.ready is always 1.
module verirq_controller
    import verirq_pkg::*;
#(
    parameter int SOURCE_COUNT        = 8,
    parameter int LOCAL_ADDRESS_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    Verbus.read_write_response      bus,
    input  logic [SOURCE_COUNT-1:0] sources
);

    logic [SOURCE_COUNT-1:0] sources_q;
    logic [SOURCE_COUNT-1:0] pending_q,   pending_d;
    logic [SOURCE_COUNT-1:0] enable_q,    enable_d;
    logic [SOURCE_COUNT-1:0] edge_mode_q, edge_mode_d;
    state_t                  state_q,     state_d;
    source_id_t              claimed_id_q, claimed_id_d;

    logic [LOCAL_ADDRESS_WIDTH-1:0] local_address;
    logic                           read_access, write_access;
    logic                           candidate_vld;
    source_id_t                     candidate_id;
    logic                           claim_take, complete;
    logic [SOURCE_COUNT-1:0]        claim_mask, after_w1c, rise, in_service;
    logic                           unused_address_bits;

    assign local_address       = bus.address[2 +: LOCAL_ADDRESS_WIDTH];
    assign unused_address_bits = ^{bus.address[31:2+LOCAL_ADDRESS_WIDTH], bus.address[1:0]};
    assign read_access         = bus.valid && (bus.wstrobe == 4'b0000);
    assign write_access        = bus.valid && (bus.wstrobe != 4'b0000);
    assign rise                = sources & ~sources_q;

    verirq_priority_encoder #(.SOURCE_COUNT(SOURCE_COUNT)) u_priority_encoder (
        .request_i (pending_q & enable_q),
        .valid_o   (candidate_vld),
        .id_o      (candidate_id)
    );

    assign in_service = (state_q == CLAIMED)
                      ? (SOURCE_COUNT'(1) << (claimed_id_q - 5'd1)) : '0;

    always_comb begin
        claim_take = read_access && (local_address == LOCAL_ADDRESS_WIDTH'(CLAIM_ADDRESS))
                  && (state_q == IDLE) && candidate_vld;
        complete   = write_access && (local_address == LOCAL_ADDRESS_WIDTH'(CLAIM_ADDRESS))
                  && (state_q == CLAIMED)
                  && (write_into(32'(claimed_id_q), bus.wdata, bus.wstrobe) == 32'(claimed_id_q));
        claim_mask = claim_take ? (SOURCE_COUNT'(1) << (candidate_id - 5'd1)) : '0;

        after_w1c = pending_q;
        enable_d  = enable_q;
        edge_mode_d = edge_mode_q;
        if (write_access) begin
            if (local_address == LOCAL_ADDRESS_WIDTH'(PENDING_ADDRESS))
                after_w1c = SOURCE_COUNT'(clear_into(32'(pending_q), bus.wdata, bus.wstrobe));
            if (local_address == LOCAL_ADDRESS_WIDTH'(ENABLE_ADDRESS))
                enable_d = SOURCE_COUNT'(write_into(32'(enable_q), bus.wdata, bus.wstrobe));
            if (local_address == LOCAL_ADDRESS_WIDTH'(EDGE_MODE_ADDRESS))
                edge_mode_d = SOURCE_COUNT'(write_into(32'(edge_mode_q), bus.wdata, bus.wstrobe));
        end

        // New edges are OR-ed in last so they survive both W1C and a claim on the same bit.
        pending_d = (edge_mode_q & ((after_w1c & ~claim_mask) | rise))
                  | (~edge_mode_q & sources);

        state_d      = state_q;
        claimed_id_d = claimed_id_q;
        if (claim_take) begin
            state_d      = CLAIMED;
            claimed_id_d = candidate_id;
        end else if (complete) begin
            state_d      = IDLE;
            claimed_id_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sources_q    <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            edge_mode_q  <= '0;
            state_q      <= IDLE;
            claimed_id_q <= '0;
        end else begin
            sources_q    <= sources;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            edge_mode_q  <= edge_mode_d;
            state_q      <= state_d;
            claimed_id_q <= claimed_id_d;
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (local_address)
            LOCAL_ADDRESS_WIDTH'(PENDING_ADDRESS):    bus.rdata = 32'(pending_q);
            LOCAL_ADDRESS_WIDTH'(ENABLE_ADDRESS):     bus.rdata = 32'(enable_q);
            LOCAL_ADDRESS_WIDTH'(EDGE_MODE_ADDRESS):  bus.rdata = 32'(edge_mode_q);
            LOCAL_ADDRESS_WIDTH'(CLAIM_ADDRESS):
                bus.rdata = (state_q == IDLE) ? 32'(candidate_id) : 32'(claimed_id_q);
            LOCAL_ADDRESS_WIDTH'(IN_SERVICE_ADDRESS): bus.rdata = 32'(in_service);
            default:                                  bus.rdata = '0;
        endcase
    end

    assign bus.ready = 1'b1;
    assign bus.irq   = (state_q == IDLE) && candidate_vld;

endmodule

// File: tb/tb_verirq_controller.sv
// Directed self-checking bench for verirq_controller with hand-computed expectations.
module tb_verirq_controller;

    localparam logic [2:0] A_PEND = 3'd0, A_EN = 3'd1, A_EDGE = 3'd2,
                           A_CLAIM = 3'd3, A_INSV = 3'd4, A_RSVD = 3'd5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sources = '0;
    logic [31:0] rv;
    int checks = 0;
    int errors = 0;

    Verbus bus_if();

    verirq_controller #(.SOURCE_COUNT(8), .LOCAL_ADDRESS_WIDTH(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if),
        .sources (sources)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.valid   = 1'b1;
        bus_if.wstrobe = 4'hF;
        bus_if.address = {27'b0, a, 2'b00};
        bus_if.wdata   = d;
        @(posedge clk);
        #1;
        bus_if.valid   = 1'b0;
        bus_if.wstrobe = 4'h0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus_if.valid   = 1'b1;
        bus_if.wstrobe = 4'h0;
        bus_if.address = {27'b0, a, 2'b00};
        #1;
        d = bus_if.rdata;
        @(posedge clk);
        #1;
        bus_if.valid = 1'b0;
    endtask

    initial begin
        bus_if.valid   = 1'b0;
        bus_if.wstrobe = 4'h0;
        bus_if.address = '0;
        bus_if.wdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state.
        rd(A_PEND, rv);  check("reset_pending", rv, 32'h0);
        rd(A_EN, rv);    check("reset_enable", rv, 32'h0);
        rd(A_EDGE, rv);  check("reset_edge", rv, 32'h0);
        rd(A_CLAIM, rv); check("reset_claim", rv, 32'h0);
        rd(A_INSV, rv);  check("reset_in_service", rv, 32'h0);
        check("reset_irq", {31'b0, bus_if.irq}, 32'h0);
        check("ready", {31'b0, bus_if.ready}, 32'h1);
        wr(A_RSVD, 32'hFF);
        rd(A_RSVD, rv);  check("reserved_read", rv, 32'h0);

        // Edge source 0 pulse, claim and complete.
        wr(A_EN, 32'h05);
        wr(A_EDGE, 32'h01);
        rd(A_EN, rv);    check("enable_readback", rv, 32'h05);
        @(negedge clk); sources = 8'h01;
        @(negedge clk); check("edge_irq", {31'b0, bus_if.irq}, 32'h1); sources = 8'h00;
        rd(A_PEND, rv);  check("edge_pending", rv, 32'h01);
        rd(A_CLAIM, rv); check("edge_claim", rv, 32'd1);
        check("claimed_irq_low", {31'b0, bus_if.irq}, 32'h0);
        rd(A_INSV, rv);  check("edge_in_service", rv, 32'h01);
        rd(A_PEND, rv);  check("edge_pending_cleared", rv, 32'h00);
        wr(A_CLAIM, 32'd1);
        rd(A_INSV, rv);  check("edge_complete_insv", rv, 32'h00);
        check("edge_complete_irq", {31'b0, bus_if.irq}, 32'h0);

        // Level source 2 held high.
        @(negedge clk); sources = 8'h04;
        wr(A_EN, 32'h04);
        rd(A_CLAIM, rv); check("level_claim", rv, 32'd3);
        check("level_claimed_irq", {31'b0, bus_if.irq}, 32'h0);
        rd(A_CLAIM, rv); check("level_claim_again", rv, 32'd3);
        wr(A_CLAIM, 32'd5);
        rd(A_INSV, rv);  check("level_wrong_complete", rv, 32'h04);
        wr(A_CLAIM, 32'd3);
        check("level_irq_reassert", {31'b0, bus_if.irq}, 32'h1);
        rd(A_INSV, rv);  check("level_complete_insv", rv, 32'h00);
        @(negedge clk); sources = 8'h00;

        // Sources 1 and 6 edge-pending: priority order.
        wr(A_EDGE, 32'h42);
        wr(A_EN, 32'h42);
        @(negedge clk); sources = 8'h42;
        @(negedge clk); sources = 8'h00;
        rd(A_PEND, rv);  check("prio_pending", rv, 32'h42);
        rd(A_CLAIM, rv); check("prio_claim_first", rv, 32'd2);
        rd(A_PEND, rv);  check("prio_pending_after", rv, 32'h40);
        wr(A_CLAIM, 32'd2);
        rd(A_CLAIM, rv); check("prio_claim_second", rv, 32'd7);
        wr(A_CLAIM, 32'd7);
        rd(A_PEND, rv);  check("prio_pending_empty", rv, 32'h00);

        // W1C versus a simultaneous rising edge on source 0.
        wr(A_EN, 32'h00);
        wr(A_EDGE, 32'h01);
        @(negedge clk); sources = 8'h01;
        @(negedge clk); sources = 8'h00;
        rd(A_PEND, rv);  check("w1c_before", rv, 32'h01);
        wr(A_PEND, 32'h01);
        rd(A_PEND, rv);  check("w1c_clears", rv, 32'h00);
        @(negedge clk); sources = 8'h01;
        @(negedge clk); sources = 8'h00;
        rd(A_PEND, rv);  check("w1c_repend", rv, 32'h01);
        @(negedge clk);
        sources        = 8'h01;
        bus_if.valid   = 1'b1;
        bus_if.wstrobe = 4'hF;
        bus_if.address = {27'b0, A_PEND, 2'b00};
        bus_if.wdata   = 32'h01;
        @(posedge clk);
        #1;
        bus_if.valid   = 1'b0;
        bus_if.wstrobe = 4'h0;
        @(negedge clk); sources = 8'h00;
        rd(A_PEND, rv);  check("w1c_edge_wins", rv, 32'h01);

        // Reset asserted while CLAIMED with level PENDING=0x0F.
        wr(A_EDGE, 32'h00);
        wr(A_EN, 32'h0F);
        @(negedge clk); sources = 8'h0F;
        @(negedge clk);
        rd(A_CLAIM, rv); check("rst_claim", rv, 32'd1);
        wr(A_PEND, 32'hFF);
        rd(A_PEND, rv);  check("level_w1c_ignored", rv, 32'h0F);
        rd(A_INSV, rv);  check("rst_in_service_before", rv, 32'h01);
        @(negedge clk); reset = 1'b1; sources = 8'h00;
        @(negedge clk); reset = 1'b0;
        check("rst_irq", {31'b0, bus_if.irq}, 32'h0);
        rd(A_PEND, rv);  check("rst_pending", rv, 32'h00);
        rd(A_EN, rv);    check("rst_enable", rv, 32'h00);
        rd(A_INSV, rv);  check("rst_in_service", rv, 32'h00);
        rd(A_CLAIM, rv); check("rst_claim_after", rv, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
